// File: rtl/manchester_unescape.sv
// manchester_unescape: AXI-Stream byte decoder, receive-side inverse of manchester_escape.
//   ESC_SYM START_CODE -> START_SYM with tuser = 1 (start of frame)
//   ESC_SYM ESC_SYM    -> ESC_SYM data byte
//   Any other byte after ESC_SYM, or ESC_SYM carrying tlast, is illegal: dropped, esc_err pulses.
// Optional feature: define MANCHESTER_UNESCAPE_ERR_CNT_EN to add the saturating 16-bit err_count port.
module manchester_unescape #(
  parameter int unsigned              DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]    ESC_SYM    = 8'hE5,
  parameter logic [DATA_WIDTH-1:0]    START_SYM  = 8'hD5,
  parameter logic [DATA_WIDTH-1:0]    START_CODE = 8'hF5
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  esc_err
`ifdef MANCHESTER_UNESCAPE_ERR_CNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  typedef enum logic {
    NORMAL   = 1'b0,
    ESC_SEEN = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;

  logic                  accept;
  logic                  is_esc;
  logic                  is_start_code;

  logic                  emit;
  logic [DATA_WIDTH-1:0] emit_data;
  logic                  emit_user;
  logic                  err;

  // Output register can take a new beat when empty or draining this cycle.
  always_comb begin
    s_axis_tready = !m_axis_tvalid || m_axis_tready;
    accept        = s_axis_tvalid && s_axis_tready;
    is_esc        = (s_axis_tdata == ESC_SYM);
    is_start_code = (s_axis_tdata == START_CODE);
  end

  // State register; reset discards any pending escape.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= NORMAL;
    end else begin
      state <= state_next;
    end
  end

  // Next state: only an ESC without tlast opens a pair; any byte in ESC_SEEN closes it.
  always_comb begin
    state_next = state;
    if (accept) begin
      unique case (state)
        NORMAL:   if (is_esc && !s_axis_tlast) state_next = ESC_SEEN;
        ESC_SEEN: state_next = NORMAL;
        default:  state_next = NORMAL;
      endcase
    end
  end

  // Decode the accepted byte into an output beat or an error.
  always_comb begin
    emit      = 1'b0;
    emit_data = s_axis_tdata;
    emit_user = 1'b0;
    err       = 1'b0;
    if (accept) begin
      unique case (state)
        NORMAL: begin
          if (!is_esc) begin
            emit = 1'b1;
          end else if (s_axis_tlast) begin
            err = 1'b1;
          end
        end
        ESC_SEEN: begin
          if (is_esc) begin
            emit = 1'b1;
          end else if (is_start_code) begin
            emit      = 1'b1;
            emit_data = START_SYM;
            emit_user = 1'b1;
          end else begin
            err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered output stage; payload held while stalled, valid cleared once drained.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      esc_err       <= 1'b0;
    end else begin
      esc_err <= err;
      if (emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= emit_data;
        m_axis_tlast  <= s_axis_tlast;
        m_axis_tuser  <= emit_user;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef MANCHESTER_UNESCAPE_ERR_CNT_EN
  // Saturating count of esc_err pulses; cleared only by reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_count <= '0;
    end else if (esc_err && (err_count != '1)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
